reg_wbus_arbiter: RTL and testbench
===================================

Name: reg_wbus_arbiter

Overview:
- Arbitrates the shared register write bus (reg_wen/blk_wen/blk_wstart/reg_waddr/reg_wdata) between two masters: req0 = FireWire link, req1 = real-time block-write engine (WriteRtData).
- Replaces the fixed combinational priority mux.
- Grants whole transactions, so a block write (blk_wstart … last blk_wen) is never split or interleaved.
- Adds a hold-timeout watchdog and registered outputs for timing closure.

Parameters:
- HOLD_TIMEOUT, 4096, max sysclk cycles a grant may be held before forced revoke; range 2..65535.
- RR_EN_DEFAULT, 1, reset value of round-robin mode. 0 = fixed priority, req1 over req0.

Ports:
- sysclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rr_mode  in  1  1 = round-robin, 0 = fixed priority; sampled only in IDLE.
- req0_req / req1_req  in  1  request; held high for the whole transaction.
- req0_gnt / req1_gnt  out  1  grant.
- reqN_reg_wen, reqN_blk_wen, reqN_blk_wstart  in  1 each  master write strobes.
- reqN_waddr  in  16  master write address.
- reqN_wdata  in  32  master write data.
- reg_wen, blk_wen, blk_wstart  out  1  arbitrated strobes (registered).
- reg_waddr  out  16  arbitrated write address (registered).
- reg_wdata  out  32  arbitrated write data (registered).
- owner  out  2  00 none, 01 req0, 10 req1.
- arb_timeout  out  1  one-cycle pulse on forced revoke.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_owner = req1 (so req0 wins the first round-robin tie); hold counter 0.
- IDLE:
  - No request: remain.
  - One request: GNT of that requester.
  - Both requests: rr_mode=1 → grant the non-last_owner; rr_mode=0 → grant req1.
  - reqN_gnt rises the cycle after entering GNTN (1-cycle request→grant latency).
- GNTN:
  - Bus outputs = reqN signals delayed one cycle.
  - The other master's strobes are ignored (dropped, never queued).
  - Hold counter increments each cycle.
  - reqN_req low → RELEASE.
  - Counter == HOLD_TIMEOUT-1 → RELEASE, pulse arb_timeout, clear gnt.
  - Strobes presented in the timeout cycle are still forwarded.
- RELEASE:
  - One dead cycle: all strobes forced 0, gnt 0, last_owner updated, counter cleared.
  - Next state IDLE.
  - Minimum gap between owners: 2 cycles (RELEASE + IDLE decision).
- Protocol rules:
  - Master must see its gnt before issuing strobes; strobes issued without gnt are discarded.
  - reg_wen and blk_wen may both be high; they are forwarded unchanged.
  - After a timeout, a master whose req is still high is treated as a new request in IDLE. Round-robin then favours the other master if it is requesting.
  - A request deasserted in the same cycle as the timeout: single RELEASE, arb_timeout still pulses.
  - Reset mid-grant: immediate IDLE, all strobes 0 next cycle; a partial block write is abandoned.
  - rr_mode changes during a grant take effect at the next IDLE.
- Widths: hold counter 16 bits; saturating comparison against HOLD_TIMEOUT-1.

Optional Feature:
- Macro: WBUS_ARB_STATS_EN.
- When defined:
  - Adds output arb_stats [31:0] = {timeout_cnt[7:0], gnt1_cnt[11:0], gnt0_cnt[11:0]}.
  - gntN_cnt increments on each GNTN entry; timeout_cnt increments on each arb_timeout.
  - All counters wrap at max and clear on reset.
  - Intended for mux into a spare chan0 register.
- When undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared package/header (`include'd with Constants.v):
  - State encodings ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2, ARB_RELEASE=2'd3.
  - Owner codes.
  - Stats field offsets.
- Sub-module wbus_hold_timer: 16-bit counter with clear/enable and expire flag. Used once; isolates the timeout for unit test.
- Arbiter FSM and output register stay in the top module.

Test Plan:
- Single master: req0_req=1, reg_wen pulse with waddr=16'h0003, wdata=32'hDEADBEEF after gnt → reg_wen=1 with the same addr/data exactly one cycle later; owner=01.
- Simultaneous requests, rr_mode=1, from reset → req0 granted first. req0 releases → RELEASE, IDLE, then req1 granted. Gap of 2 cycles with all strobes 0.
- Fixed priority: rr_mode=0, both requesting repeatedly → req1 wins every arbitration; req0 is granted only when req1_req=0.
- Block integrity: req1 block write (blk_wstart, then 16 blk_wen) while req0 requests mid-burst → all 17 strobes forwarded contiguously; req0 gnt rises no earlier than 2 cycles after req1_req falls.
- Timeout: HOLD_TIMEOUT=8, req0 holds indefinitely → gnt0 drops 8 cycles after rising; arb_timeout pulses once; req1 (pending) granted next.
- Reset mid-grant: assert reset during req1 block write → next cycle all outputs 0, owner=00; with WBUS_ARB_STATS_EN, arb_stats=0.

Source files
------------

// File: rtl/reg_wbus_arbiter_pkg.sv
// Shared encodings for the register write-bus arbiter.
// Stats field offsets exist only when WBUS_ARB_STATS_EN is defined.
package reg_wbus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GNT0    = 2'd1,
    ARB_GNT1    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_REQ0 = 2'b01,
    OWN_REQ1 = 2'b10
  } owner_e;

`ifdef WBUS_ARB_STATS_EN
  localparam int STATS_GNT0_LSB = 0;
  localparam int STATS_GNT1_LSB = 12;
  localparam int STATS_TMO_LSB  = 24;
`endif

  // On a tie, round-robin hands the bus to whoever did not own it last.
  function automatic arb_state_e pick_grant(input logic r0, input logic r1,
                                            input logic rr, input logic last_is_req1);
    if (r0 && r1) begin
      if (rr) return last_is_req1 ? ARB_GNT0 : ARB_GNT1;
      return ARB_GNT1;
    end
    if (r0) return ARB_GNT0;
    if (r1) return ARB_GNT1;
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/reg_wbus_arbiter_if.sv
// Request/grant handshake for both masters plus the arbitrated write bus.
interface reg_wbus_arbiter_if;
  logic        req0_req, req0_gnt, req0_reg_wen, req0_blk_wen, req0_blk_wstart;
  logic [15:0] req0_waddr;
  logic [31:0] req0_wdata;
  logic        req1_req, req1_gnt, req1_reg_wen, req1_blk_wen, req1_blk_wstart;
  logic [15:0] req1_waddr;
  logic [31:0] req1_wdata;
  logic        reg_wen, blk_wen, blk_wstart;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic [1:0]  owner;
  logic        arb_timeout;

  modport master (
    output req0_req, req0_reg_wen, req0_blk_wen, req0_blk_wstart, req0_waddr, req0_wdata,
    output req1_req, req1_reg_wen, req1_blk_wen, req1_blk_wstart, req1_waddr, req1_wdata,
    input  req0_gnt, req1_gnt, reg_wen, blk_wen, blk_wstart, reg_waddr, reg_wdata,
    input  owner, arb_timeout
  );

  modport slave (
    input  req0_req, req0_reg_wen, req0_blk_wen, req0_blk_wstart, req0_waddr, req0_wdata,
    input  req1_req, req1_reg_wen, req1_blk_wen, req1_blk_wstart, req1_waddr, req1_wdata,
    output req0_gnt, req1_gnt, reg_wen, blk_wen, blk_wstart, reg_waddr, reg_wdata,
    output owner, arb_timeout
  );
endinterface

// File: rtl/reg_wbus_arbiter_hold_timer.sv
// Grant hold counter: counts while enabled, flags expiry at HOLD_TIMEOUT-1.
module reg_wbus_arbiter_hold_timer #(
  parameter int unsigned HOLD_TIMEOUT = 4096
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [15:0] LIMIT = 16'(HOLD_TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                          cnt_d = '0;
    else if (en_i && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge sysclk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/reg_wbus_arbiter.sv
// Whole-transaction arbiter for the shared register write bus, with hold watchdog.
// Optional grant/timeout statistics output enabled by WBUS_ARB_STATS_EN.
module reg_wbus_arbiter
  import reg_wbus_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_TIMEOUT  = 4096,
  parameter bit          RR_EN_DEFAULT = 1'b1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              rr_mode,
  reg_wbus_arbiter_if.slave bus
`ifdef WBUS_ARB_STATS_EN
  ,
  output logic [31:0]       arb_stats
`endif
);

  arb_state_e  state_q, pick;
  owner_e      owner_q;
  logic        last_req1_q, rr_q, gnt0_q, gnt1_q, timeout_q;
  logic        reg_wen_q, blk_wen_q, blk_wstart_q;
  logic [15:0] waddr_q;
  logic [31:0] wdata_q;
  logic        in_gnt, expire;

  assign in_gnt = (state_q == ARB_GNT0) || (state_q == ARB_GNT1);
  assign pick   = pick_grant(bus.req0_req, bus.req1_req, rr_q, last_req1_q);

  reg_wbus_arbiter_hold_timer #(.HOLD_TIMEOUT(HOLD_TIMEOUT)) u_hold_timer (
    .sysclk   (sysclk),
    .reset    (reset),
    .clr_i    (!in_gnt),
    .en_i     (in_gnt),
    .expire_o (expire)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_NONE;
      last_req1_q  <= 1'b1;
      rr_q         <= RR_EN_DEFAULT;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      timeout_q    <= 1'b0;
      reg_wen_q    <= 1'b0;
      blk_wen_q    <= 1'b0;
      blk_wstart_q <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      // Bus register is zero unless the current owner is forwarded below.
      timeout_q    <= 1'b0;
      reg_wen_q    <= 1'b0;
      blk_wen_q    <= 1'b0;
      blk_wstart_q <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      unique case (state_q)
        ARB_IDLE: begin
          rr_q    <= rr_mode;
          state_q <= pick;
          gnt0_q  <= (pick == ARB_GNT0);
          gnt1_q  <= (pick == ARB_GNT1);
          owner_q <= (pick == ARB_GNT0) ? OWN_REQ0 :
                     (pick == ARB_GNT1) ? OWN_REQ1 : OWN_NONE;
        end
        ARB_GNT0: begin
          reg_wen_q    <= bus.req0_reg_wen;
          blk_wen_q    <= bus.req0_blk_wen;
          blk_wstart_q <= bus.req0_blk_wstart;
          waddr_q      <= bus.req0_waddr;
          wdata_q      <= bus.req0_wdata;
          if (expire || !bus.req0_req) begin
            state_q     <= ARB_RELEASE;
            gnt0_q      <= 1'b0;
            owner_q     <= OWN_NONE;
            timeout_q   <= expire;
            last_req1_q <= 1'b0;
          end
        end
        ARB_GNT1: begin
          reg_wen_q    <= bus.req1_reg_wen;
          blk_wen_q    <= bus.req1_blk_wen;
          blk_wstart_q <= bus.req1_blk_wstart;
          waddr_q      <= bus.req1_waddr;
          wdata_q      <= bus.req1_wdata;
          if (expire || !bus.req1_req) begin
            state_q     <= ARB_RELEASE;
            gnt1_q      <= 1'b0;
            owner_q     <= OWN_NONE;
            timeout_q   <= expire;
            last_req1_q <= 1'b1;
          end
        end
        ARB_RELEASE: begin
          rr_q    <= rr_mode;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_gnt    = gnt0_q;
  assign bus.req1_gnt    = gnt1_q;
  assign bus.reg_wen     = reg_wen_q;
  assign bus.blk_wen     = blk_wen_q;
  assign bus.blk_wstart  = blk_wstart_q;
  assign bus.reg_waddr   = waddr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.owner       = owner_q;
  assign bus.arb_timeout = timeout_q;

`ifdef WBUS_ARB_STATS_EN
  logic [11:0] gnt0_cnt_q, gnt1_cnt_q;
  logic [7:0]  tmo_cnt_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      if (state_q == ARB_IDLE && pick == ARB_GNT0) gnt0_cnt_q <= gnt0_cnt_q + 12'd1;
      if (state_q == ARB_IDLE && pick == ARB_GNT1) gnt1_cnt_q <= gnt1_cnt_q + 12'd1;
      if (timeout_q)                               tmo_cnt_q  <= tmo_cnt_q + 8'd1;
    end
  end

  always_comb begin
    arb_stats                       = '0;
    arb_stats[STATS_GNT0_LSB +: 12] = gnt0_cnt_q;
    arb_stats[STATS_GNT1_LSB +: 12] = gnt1_cnt_q;
    arb_stats[STATS_TMO_LSB  +: 8]  = tmo_cnt_q;
  end
`endif

endmodule

// File: tb/tb_reg_wbus_arbiter.sv
// Scoreboard bench for reg_wbus_arbiter: forwarded strobes are queued at drive time
// and compared (content and one-cycle latency) when they appear on the bus.
module tb_reg_wbus_arbiter;

  localparam int unsigned HT = 24;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  logic rr_mode = 1'b1;

  always #5 sysclk = ~sysclk;

  reg_wbus_arbiter_if bus();
`ifdef WBUS_ARB_STATS_EN
  logic [31:0] arb_stats;
`endif

  reg_wbus_arbiter #(.HOLD_TIMEOUT(HT), .RR_EN_DEFAULT(1'b1)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .rr_mode (rr_mode),
    .bus     (bus.slave)
`ifdef WBUS_ARB_STATS_EN
    ,
    .arb_stats (arb_stats)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [50:0] exp_q[$];
  int          exp_cyc_q[$];
  int run_len = 0, max_run = 0, g0_run = 0, last_g0_run = 0, tmo_cnt = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge sysclk) cyc++;

  always @(negedge sysclk) begin
    logic [50:0] act, e;
    int c;
    act = {bus.blk_wstart, bus.blk_wen, bus.reg_wen, bus.reg_waddr, bus.reg_wdata};
    if (act[50:48] != 3'b000) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_strobe", 64'(act), 64'd0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk_eq("bus_data", 64'(act), 64'(e));
        chk_eq("bus_latency", 64'(cyc), 64'(c));
      end
    end else begin
      run_len = 0;
    end
    if (bus.req0_gnt) g0_run++;
    else begin
      if (g0_run != 0) last_g0_run = g0_run;
      g0_run = 0;
    end
    if (bus.arb_timeout) tmo_cnt++;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic strobe(input int m, input logic rw, input logic bw, input logic ws,
                        input logic [15:0] a, input logic [31:0] d, input bit fwd);
    if (m == 0) {bus.req0_blk_wstart, bus.req0_blk_wen, bus.req0_reg_wen, bus.req0_waddr, bus.req0_wdata} = {ws, bw, rw, a, d};
    else        {bus.req1_blk_wstart, bus.req1_blk_wen, bus.req1_reg_wen, bus.req1_waddr, bus.req1_wdata} = {ws, bw, rw, a, d};
    if (fwd) begin
      exp_q.push_back({ws, bw, rw, a, d});
      exp_cyc_q.push_back(cyc + 1);
    end
    tick();
    if (m == 0) {bus.req0_blk_wstart, bus.req0_blk_wen, bus.req0_reg_wen, bus.req0_waddr, bus.req0_wdata} = '0;
    else        {bus.req1_blk_wstart, bus.req1_blk_wen, bus.req1_reg_wen, bus.req1_waddr, bus.req1_wdata} = '0;
  endtask

  function automatic logic gnt_of(input int m);
    return (m == 0) ? bus.req0_gnt : bus.req1_gnt;
  endfunction

  // Number of negedges until the grant is seen; -1 if it never comes.
  task automatic wait_gnt(input int m, output int waited);
    waited = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sysclk);
      if (gnt_of(m)) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    chk_eq(tag, 64'({bus.req0_gnt, bus.req1_gnt, bus.owner, bus.arb_timeout,
                     bus.reg_wen, bus.blk_wen, bus.blk_wstart}), 64'd0);
    chk_eq({tag, "_addr_data"}, 64'({bus.reg_waddr, bus.reg_wdata}), 64'd0);
`ifdef WBUS_ARB_STATS_EN
    chk_eq({tag, "_stats"}, 64'(arb_stats), 64'd0);
`endif
  endtask

  initial begin
    int w, gap;
    {bus.req0_req, bus.req0_reg_wen, bus.req0_blk_wen, bus.req0_blk_wstart, bus.req0_waddr, bus.req0_wdata} = '0;
    {bus.req1_req, bus.req1_reg_wen, bus.req1_blk_wen, bus.req1_blk_wstart, bus.req1_waddr, bus.req1_wdata} = '0;
    repeat (2) tick();
    @(negedge sysclk);
    check_quiet("reset_state");
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Single master, plus strobes from the non-granted master that must be dropped.
    bus.req0_req = 1'b1;
    wait_gnt(0, w);
    chk_eq("t1_gnt0_latency", 64'(w), 64'd2);
    chk_eq("t1_owner", 64'(bus.owner), 64'd1);
    chk_eq("t1_gnt1_low", 64'(bus.req1_gnt), 64'd0);
    strobe(0, 1'b1, 1'b0, 1'b0, 16'h0003, 32'hDEADBEEF, 1'b1);
    strobe(0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h12345678, 1'b1);
    strobe(1, 1'b1, 1'b0, 1'b0, 16'hBAD0, 32'hBADBAD00, 1'b0);
    bus.req0_req = 1'b0;
    repeat (4) tick();
    @(negedge sysclk);
    chk_eq("t1_owner_released", 64'(bus.owner), 64'd0);
    tick();

    // Round-robin from reset: req0 first, then a 2-cycle dead gap before req1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0_req = 1'b1;
    bus.req1_req = 1'b1;
    wait_gnt(0, w);
    chk_eq("t2_rr_req0_first", 64'(w), 64'd2);
    chk_eq("t2_gnt1_low", 64'(bus.req1_gnt), 64'd0);
    strobe(0, 1'b1, 1'b0, 1'b0, 16'h0100, 32'h00000001, 1'b1);
    bus.req0_req = 1'b0;
    gap = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sysclk);
      if (bus.req1_gnt) break;
      if (!bus.req0_gnt) gap++;
    end
    chk_eq("t2_gap_cycles", 64'(gap), 64'd2);
    chk_eq("t2_owner_req1", 64'(bus.owner), 64'd2);
    strobe(1, 1'b1, 1'b0, 1'b0, 16'h0200, 32'h00000002, 1'b1);
    bus.req1_req = 1'b0;
    repeat (4) tick();

    // Fixed priority: req1 keeps winning while it re-requests.
    rr_mode = 1'b0;
    repeat (2) tick();
    bus.req0_req = 1'b1;
    bus.req1_req = 1'b1;
    wait_gnt(1, w);
    chk_eq("t3_fixed_first", 64'(w), 64'd2);
    chk_eq("t3_gnt0_low", 64'(bus.req0_gnt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      strobe(1, 1'b1, 1'b0, 1'b0, 16'h0300 + 16'(k), 32'hF1F00000 + 32'(k), 1'b1);
      bus.req1_req = 1'b0;
      tick();
      bus.req1_req = 1'b1;
      wait_gnt(1, w);
      chk_eq("t3_req1_regrant", 64'(w), 64'd3);
      chk_eq("t3_req0_blocked", 64'(bus.req0_gnt), 64'd0);
    end
    strobe(1, 1'b1, 1'b0, 1'b0, 16'h0310, 32'hF1F00010, 1'b1);
    bus.req1_req = 1'b0;
    wait_gnt(0, w);
    chk_eq("t3_req0_after_req1", 64'(w), 64'd4);
    strobe(0, 1'b1, 1'b0, 1'b0, 16'h0320, 32'hF1F00020, 1'b1);
    bus.req0_req = 1'b0;
    rr_mode = 1'b1;
    repeat (4) tick();

    // Block write by req1 with req0 requesting (and strobing) mid-burst.
    bus.req1_req = 1'b1;
    wait_gnt(1, w);
    chk_eq("t4_gnt1", 64'(w), 64'd2);
    max_run = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 4) begin
        bus.req0_req = 1'b1;
        bus.req0_reg_wen = 1'b1;
        bus.req0_blk_wen = 1'b1;
        bus.req0_waddr = 16'hEEEE;
        bus.req0_wdata = 32'hEEEEEEEE;
      end
      strobe(1, 1'b0, (k != 0), (k == 0), 16'h1000 + 16'(k), $urandom, 1'b1);
    end
    bus.req1_req = 1'b0;
    {bus.req0_reg_wen, bus.req0_blk_wen, bus.req0_waddr, bus.req0_wdata} = '0;
    wait_gnt(0, w);
    chk_eq("t4_gnt0_delay", 64'(w), 64'd4);
    chk_eq("t4_burst_contiguous", 64'(max_run), 64'd17);

    // Timeout: req0 holds with req1 pending; strobes up to the timeout cycle are forwarded.
    tmo_cnt = 0;
    bus.req1_req = 1'b1;
    for (int k = 0; k < int'(HT); k++)
      strobe(0, 1'b1, 1'b0, 1'b0, 16'h3000 + 16'(k), 32'hA5000000 + 32'(k), 1'b1);
    wait_gnt(1, w);
    chk_eq("t5_req1_after_timeout", 64'(w), 64'd3);
    chk_eq("t5_hold_len", 64'(last_g0_run), 64'(HT));
    chk_eq("t5_timeout_pulses", 64'(tmo_cnt), 64'd1);
    chk_eq("t5_gnt0_low", 64'(bus.req0_gnt), 64'd0);
`ifdef WBUS_ARB_STATS_EN
    chk_eq("t5_stats", 64'(arb_stats), 64'({8'd1, 12'd7, 12'd3}));
`endif

    // Reset in the middle of a req1 block write.
    strobe(1, 1'b0, 1'b0, 1'b1, 16'h2000, 32'h11111111, 1'b1);
    strobe(1, 1'b0, 1'b1, 1'b0, 16'h2001, 32'h22222222, 1'b1);
    bus.req1_blk_wen = 1'b1;
    bus.req1_waddr = 16'h2002;
    bus.req1_wdata = 32'h33333333;
    reset = 1'b1;
    tick();
    @(negedge sysclk);
    check_quiet("t6_reset_midgrant");
    chk_eq("t6_queue_drained", 64'(exp_q.size()), 64'd0);
    {bus.req1_blk_wen, bus.req1_waddr, bus.req1_wdata} = '0;
    bus.req0_req = 1'b0;
    bus.req1_req = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Request dropped in the timeout cycle: one release, one pulse.
    tmo_cnt = 0;
    bus.req0_req = 1'b1;
    wait_gnt(0, w);
    chk_eq("t7_gnt0", 64'(w), 64'd2);
    repeat (HT - 1) tick();
    bus.req0_req = 1'b0;
    repeat (5) tick();
    chk_eq("t7_hold_len", 64'(last_g0_run), 64'(HT));
    chk_eq("t7_timeout_pulses", 64'(tmo_cnt), 64'd1);
    chk_eq("t7_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
